gemm_result_reader: RTL
=======================

GEMM_RESULT_READER -- requirements
Module: gemm_result_reader

Interface
REQ-001 Parameter OutDataWidth, default 32, result element width in bits.
REQ-002 Parameter AddrWidth, default 12, SRAM C address width.
REQ-003 Parameter SizeAddrWidth, default 8, width of the M and N size inputs.
REQ-004 clk_i  in  1  the only clock; all logic samples on the rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 start_i  in  1  one-cycle request to begin readback.
REQ-007 M_size_i  in  SizeAddrWidth  number of rows of C.
REQ-008 N_size_i  in  SizeAddrWidth  number of columns of C.
REQ-009 base_addr_i  in  AddrWidth  address of element C[0][0].
REQ-010 sram_c_addr_o  out  AddrWidth  read address to the single-port memory holding C.
REQ-011 sram_c_rdata_i  in  OutDataWidth  read data, valid one cycle after its address.
REQ-012 res_data_o  out  OutDataWidth  streamed result element (signed).
REQ-013 res_valid_o  out  1  res_data_o holds a valid element.
REQ-014 res_ready_i  in  1  consumer accepts; a beat transfers when res_valid_o and res_ready_i are both high.
REQ-015 res_last_o  out  1  high with the final element of the matrix.
REQ-016 busy_o  out  1  high whenever the block is not in IDLE.
REQ-017 done_o  out  1  one-cycle pulse when the readback completes.

Function
REQ-018 States: IDLE, READ (issuing addresses), DRAIN (all reads issued, buffer not yet empty), DONE (one cycle, asserts done_o), then back to IDLE.
REQ-019 start_i is accepted only in IDLE; M_size_i, N_size_i and base_addr_i are latched on acceptance, and start_i is ignored in any other state.
REQ-020 If the latched M or N is 0, the block goes directly to DONE: done_o pulses on the cycle after acceptance and no beat is produced.
REQ-021 Elements are read and streamed in row-major order; element (m,n) is read from base + m*N + n, computed modulo 2^AddrWidth (address wrap is permitted).
REQ-022 A read is issued only when (buffer occupancy + reads in flight) < 2, so no returned data is ever dropped.
REQ-023 Returned data is written into a 2-entry FIFO on the cycle after its address is presented; res_data_o is the FIFO head.
REQ-024 With res_ready_i held high, the first res_valid_o is asserted exactly 3 cycles after the start_i acceptance edge, and the block then sustains one beat per cycle.
REQ-025 While res_valid_o is high and res_ready_i is low, res_data_o and res_last_o are held stable and res_valid_o is not deasserted.
REQ-026 res_last_o is high only on beat number M*N-1.
REQ-027 The state moves from READ to DRAIN in the cycle after the final address is issued.
REQ-028 done_o pulses in the cycle after the handshake of the last beat; busy_o falls in the same cycle that done_o falls.
REQ-029 sram_c_addr_o holds its last value when no read is being issued.

Reset
REQ-030 While rst_i is high: state is IDLE, the FIFO is empty, and all counters are 0.
REQ-031 While rst_i is high: sram_c_addr_o, res_data_o, res_valid_o, res_last_o, busy_o and done_o are all 0.
REQ-032 Reset asserted mid-operation aborts the readback immediately; no done_o pulse is produced and no stale beat appears after reset is released.

Structure
REQ-033 The width defaults and the state enum (IDLE/READ/DRAIN/DONE) live in a shared package, gemm_pkg.
REQ-034 The 2-entry FIFO is one sub-module, result_skid_buffer, with valid/ready on both sides and an occupancy output.
REQ-035 The row counter, column counter and address counter are kept in the top module; there is no multiplier on the address path (the address is incremented by 1 per element).

Verification
REQ-036 M=2, N=3, base=0, memory = 0..5, ready held high -> beats 0,1,2,3,4,5 on consecutive cycles; first valid 3 cycles after start; res_last_o with 5; done_o one cycle later.
REQ-037 M=4, N=4, ready toggled in a pseudo-random pattern -> 16 beats in order, no loss, no duplicates, data held stable while stalled.
REQ-038 M=0, N=5 -> no beat is produced; done_o pulses 1 cycle after start.
REQ-039 base=4094, M=1, N=4, AddrWidth=12 -> reads from addresses 4094, 4095, 0, 1.
REQ-040 start_i re-pulsed while busy -> it is ignored and the original transfer completes unchanged.
REQ-041 rst_i asserted after the 3rd beat of an 8x8 readback -> all outputs are 0 next cycle; no done_o; a fresh start afterwards streams correctly from element 0.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared widths and readback state encoding for the GEMM result reader.
package gemm_pkg;

    localparam int OUT_DATA_W  = 32;
    localparam int ADDR_W      = 12;
    localparam int SIZE_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/result_skid_buffer.sv
// Two-entry FIFO between the SRAM read return and the result stream.
// r_head is always the oldest entry, so the output needs no read mux.
module result_skid_buffer
    import gemm_pkg::*;
#(
    parameter int Width = OUT_DATA_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    logic [1:0]       r_count;
    logic [Width-1:0] r_head;
    logic [Width-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign out_valid_o = (r_count != 2'd0);
    assign in_ready_o  = (r_count != 2'd2) || out_ready_i;
    assign out_data_o  = r_head;
    assign occupancy_o = r_count;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= in_data_i;
                    else                 r_tail <= in_data_i;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= in_data_i;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gemm_result_reader.sv
// Streams an M x N result matrix out of SRAM C in row-major order through
// a 2-entry buffer, with reads throttled so returned data always has a slot.
module gemm_result_reader
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = OUT_DATA_W,
    parameter int AddrWidth     = ADDR_W,
    parameter int SizeAddrWidth = SIZE_ADDR_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [SizeAddrWidth-1:0]       M_size_i,
    input  logic [SizeAddrWidth-1:0]       N_size_i,
    input  logic [AddrWidth-1:0]           base_addr_i,
    output logic [AddrWidth-1:0]           sram_c_addr_o,
    input  logic [OutDataWidth-1:0]        sram_c_rdata_i,
    output logic signed [OutDataWidth-1:0] res_data_o,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic                           res_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    rd_state_e                r_state;
    logic [SizeAddrWidth-1:0] r_m_size;
    logic [SizeAddrWidth-1:0] r_n_size;
    logic [SizeAddrWidth-1:0] r_row;
    logic [SizeAddrWidth-1:0] r_col;
    logic [AddrWidth-1:0]     r_addr;
    logic [AddrWidth-1:0]     r_sram_addr;
    logic                     r_armed;
    logic                     r_rd_pend;
    logic                     r_rd_last;

    logic                     w_zero;
    logic                     w_last_issue;
    logic                     w_issue;
    logic                     w_pop;
    logic                     w_fifo_in_ready;
    logic [1:0]               w_occ;
    logic [2:0]               w_credit;
    logic [OutDataWidth:0]    w_head;

    assign w_zero       = (M_size_i == '0) || (N_size_i == '0);
    assign w_last_issue = (r_row == r_m_size - 1'b1) && (r_col == r_n_size - 1'b1);
    assign w_pop        = res_valid_o && res_ready_i;

    // Slots committed once this cycle's pop retires: buffered plus the read whose data is on the bus.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue  = (r_state == ST_READ) && r_armed && w_fifo_in_ready && (w_credit < 3'd2);

    assign sram_c_addr_o = w_issue ? r_addr : r_sram_addr;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
    assign res_data_o    = w_head[OutDataWidth-1:0];
    assign res_last_o    = res_valid_o && w_head[OutDataWidth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_m_size    <= '0;
            r_n_size    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_sram_addr <= '0;
            r_armed     <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            r_rd_last <= w_issue && w_last_issue;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_m_size <= M_size_i;
                        r_n_size <= N_size_i;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_addr   <= base_addr_i;
                        r_armed  <= 1'b0;
                        r_state  <= w_zero ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    // First READ cycle is a setup slot, fixing first-beat latency at 3 cycles.
                    r_armed <= 1'b1;
                    if (w_issue) begin
                        r_sram_addr <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        if (r_col == r_n_size - 1'b1) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_last_issue) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head[OutDataWidth]) r_state <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    result_skid_buffer #(
        .Width(OutDataWidth + 1)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (r_rd_pend),
        .in_ready_o (w_fifo_in_ready),
        .in_data_i  ({r_rd_last, sram_c_rdata_i}),
        .out_valid_o(res_valid_o),
        .out_ready_i(res_ready_i),
        .out_data_o (w_head),
        .occupancy_o(w_occ)
    );

endmodule
